// File: rtl/axi_pkg.sv
// AXI address-phase field types used by the protection unit.
package axi_pkg;

  typedef logic [7:0] len_t;
  typedef logic [2:0] size_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

endpackage

// File: rtl/pu_pkg.sv
// Protection-unit shared types and the burst span helper.
package pu_pkg;
  import axi_pkg::*;

  // Widest address the span helper supports; one extra bit holds the carry.
  localparam int unsigned PU_MAX_AW = 64;
  localparam int unsigned PU_SW     = PU_MAX_AW + 1;

  typedef struct packed {
    logic read;
    logic write;
  } policy_entry_t;

  typedef logic [3:0] region_idx_t;
  typedef logic [3:0] domain_idx_t;

  typedef struct packed {
    logic [PU_SW-1:0] start;
    logic [PU_SW-1:0] last;
    logic             carry;
  } span_t;

  // First/last byte touched by a burst. WRAP covers its whole wrap container.
  // carry is set when the last byte lies beyond an aw-bit address space.
  function automatic span_t span_calc(input logic [PU_MAX_AW-1:0] addr,
                                      input int unsigned          aw,
                                      input len_t                 len,
                                      input size_t                size,
                                      input burst_t               burst);
    span_t            r;
    logic [PU_SW-1:0] beat_bytes;
    logic [PU_SW-1:0] burst_bytes;
    logic [PU_SW-1:0] span;
    beat_bytes  = PU_SW'(1) << size;
    burst_bytes = (PU_SW'(len) + PU_SW'(1)) << size;
    r.start     = {1'b0, addr};
    case (burst)
      BURST_FIXED: span = beat_bytes - PU_SW'(1);
      BURST_WRAP: begin
        r.start = r.start & ~(burst_bytes - PU_SW'(1));
        span    = burst_bytes - PU_SW'(1);
      end
      default:     span = burst_bytes - PU_SW'(1);
    endcase
    r.last  = r.start + span;
    r.carry = |(r.last >> aw);
    return r;
  endfunction

endpackage

// File: rtl/policy_match.sv
// Combinational region and domain match vectors for stage 1.
module policy_match #(
  parameter int unsigned NUM_MEM_REGIONS = 16,
  parameter int unsigned NUM_DOMAINS     = 16,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter logic [NUM_MEM_REGIONS-1:0][ADDR_WIDTH-1:0] MEM_REGIONS     = '0,
  parameter logic [NUM_MEM_REGIONS-1:0][31:0]           MEM_REGION_LSBS = '0,
  parameter logic [NUM_DOMAINS-1:0][ID_WIDTH-1:0]       DOMAIN_IDS      = '0,
  parameter logic [NUM_DOMAINS-1:0][ID_WIDTH-1:0]       DOMAIN_MASKS    = '1
) (
  input  logic [ADDR_WIDTH-1:0]      start_i,
  input  logic [ADDR_WIDTH-1:0]      last_i,
  input  logic [ID_WIDTH-1:0]        id_i,
  output logic [NUM_MEM_REGIONS-1:0] region_hit_o,
  output logic [NUM_DOMAINS-1:0]     domain_hit_o
);

  // A region matches when both ends of the span agree with its significant bits.
  for (genvar i = 0; i < NUM_MEM_REGIONS; i++) begin : g_region
    if (MEM_REGION_LSBS[i] >= ADDR_WIDTH) begin : g_all
      assign region_hit_o[i] = 1'b1;
    end else begin : g_cmp
      localparam logic [ADDR_WIDTH-1:0] SIG_MASK = {ADDR_WIDTH{1'b1}} << MEM_REGION_LSBS[i];
      assign region_hit_o[i] = ((start_i & SIG_MASK) == (MEM_REGIONS[i] & SIG_MASK)) &&
                               ((last_i  & SIG_MASK) == (MEM_REGIONS[i] & SIG_MASK));
    end
  end

  // A domain matches when every masked ID bit agrees.
  for (genvar j = 0; j < NUM_DOMAINS; j++) begin : g_domain
    assign domain_hit_o[j] = ((id_i ^ DOMAIN_IDS[j]) & DOMAIN_MASKS[j]) == '0;
  end

endmodule

// File: rtl/policy_check_pipe.sv
// Two-stage elastic policy checker: stage 1 computes span and match vectors,
// stage 2 looks up the programmable table and presents grant/deny.
module policy_check_pipe
  import axi_pkg::*;
  import pu_pkg::*;
#(
  parameter int unsigned NUM_MEM_REGIONS = 16,
  parameter int unsigned NUM_DOMAINS     = 16,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter logic [NUM_MEM_REGIONS-1:0][ADDR_WIDTH-1:0] MEM_REGIONS     = '0,
  parameter logic [NUM_MEM_REGIONS-1:0][31:0]           MEM_REGION_LSBS = '0,
  parameter logic [NUM_DOMAINS-1:0][ID_WIDTH-1:0]       DOMAIN_IDS      = '0,
  parameter logic [NUM_DOMAINS-1:0][ID_WIDTH-1:0]       DOMAIN_MASKS    = '1,
  parameter policy_entry_t [NUM_MEM_REGIONS-1:0][NUM_DOMAINS-1:0] POLICY_RESET = '0,
  parameter int unsigned VIOL_CNT_WIDTH  = 16
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               REQ_VALID,
  output logic                               REQ_READY,
  input  logic [ID_WIDTH-1:0]                REQ_ID,
  input  logic [ADDR_WIDTH-1:0]              REQ_ADDR,
  input  len_t                               REQ_LEN,
  input  size_t                              REQ_SIZE,
  input  burst_t                             REQ_BURST,
  input  logic                               REQ_RW,
  output logic                               RSP_VALID,
  input  logic                               RSP_READY,
  output logic                               RSP_GRANTED,
  input  logic                               CFG_WE,
  input  logic [$clog2(NUM_MEM_REGIONS)-1:0] CFG_REGION,
  input  logic [$clog2(NUM_DOMAINS)-1:0]     CFG_DOMAIN,
  input  policy_entry_t                      CFG_WDATA,
  input  logic                               CFG_LOCK,
  output logic                               CFG_LOCKED,
  input  logic                               VIOL_CLEAR,
  output logic                               VIOL_VALID,
  output logic [ID_WIDTH-1:0]                VIOL_ID,
  output logic [ADDR_WIDTH-1:0]              VIOL_ADDR,
  output logic                               VIOL_RW,
  output logic [VIOL_CNT_WIDTH-1:0]          VIOL_COUNT
);

  span_t                      span;
  logic [ADDR_WIDTH-1:0]      start_a, last_a;
  logic [NUM_MEM_REGIONS-1:0] region_hit;
  logic [NUM_DOMAINS-1:0]     domain_hit;
  logic                       unused_span_hi;

  logic                       s1_valid_q, s1_rw_q, s1_carry_q;
  logic [NUM_MEM_REGIONS-1:0] s1_region_q;
  logic [NUM_DOMAINS-1:0]     s1_domain_q;
  logic [ID_WIDTH-1:0]        s1_id_q;
  logic [ADDR_WIDTH-1:0]      s1_addr_q;

  logic                       rsp_valid_q, rsp_granted_q, rsp_rw_q;
  logic [ID_WIDTH-1:0]        rsp_id_q;
  logic [ADDR_WIDTH-1:0]      rsp_addr_q;
  logic                       grant_d;

  policy_entry_t [NUM_MEM_REGIONS-1:0][NUM_DOMAINS-1:0] table_q;
  logic                       locked_q, cfg_wr_en;

  logic                       viol_valid_q, viol_valid_d, viol_rw_q, viol_rw_d;
  logic [ID_WIDTH-1:0]        viol_id_q, viol_id_d;
  logic [ADDR_WIDTH-1:0]      viol_addr_q, viol_addr_d;
  logic [VIOL_CNT_WIDTH-1:0]  viol_cnt_q, viol_cnt_d;

  logic                       rsp_advance, req_accept, deny_hs;

  // Burst span of the incoming request.
  always_comb span = span_calc(PU_MAX_AW'(REQ_ADDR), ADDR_WIDTH, REQ_LEN, REQ_SIZE, REQ_BURST);

  assign start_a        = span.start[ADDR_WIDTH-1:0];
  assign last_a         = span.last[ADDR_WIDTH-1:0];
  assign unused_span_hi = ^{span.start[PU_SW-1:ADDR_WIDTH], span.last[PU_SW-1:ADDR_WIDTH]};

  policy_match #(
    .NUM_MEM_REGIONS (NUM_MEM_REGIONS),
    .NUM_DOMAINS     (NUM_DOMAINS),
    .ID_WIDTH        (ID_WIDTH),
    .ADDR_WIDTH      (ADDR_WIDTH),
    .MEM_REGIONS     (MEM_REGIONS),
    .MEM_REGION_LSBS (MEM_REGION_LSBS),
    .DOMAIN_IDS      (DOMAIN_IDS),
    .DOMAIN_MASKS    (DOMAIN_MASKS)
  ) u_match (
    .start_i      (start_a),
    .last_i       (last_a),
    .id_i         (REQ_ID),
    .region_hit_o (region_hit),
    .domain_hit_o (domain_hit)
  );

  assign rsp_advance = !rsp_valid_q || RSP_READY;
  assign REQ_READY   = !s1_valid_q || rsp_advance;
  assign req_accept  = REQ_VALID && REQ_READY;
  assign deny_hs     = rsp_valid_q && RSP_READY && !rsp_granted_q;

  // Stage 1 register: match vectors and request attributes.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s1_valid_q  <= 1'b0;
      s1_rw_q     <= 1'b0;
      s1_carry_q  <= 1'b0;
      s1_region_q <= '0;
      s1_domain_q <= '0;
      s1_id_q     <= '0;
      s1_addr_q   <= '0;
    end else begin
      if (REQ_READY) s1_valid_q <= REQ_VALID;
      if (req_accept) begin
        s1_rw_q     <= REQ_RW;
        s1_carry_q  <= span.carry;
        s1_region_q <= region_hit;
        s1_domain_q <= domain_hit;
        s1_id_q     <= REQ_ID;
        s1_addr_q   <= REQ_ADDR;
      end
    end
  end

  // Stage 2 decision against the live table contents.
  always_comb begin
    grant_d = 1'b0;
    for (int unsigned i = 0; i < NUM_MEM_REGIONS; i++) begin
      for (int unsigned j = 0; j < NUM_DOMAINS; j++) begin
        if (s1_region_q[i] && s1_domain_q[j] &&
            (s1_rw_q ? table_q[i][j].write : table_q[i][j].read)) begin
          grant_d = 1'b1;
        end
      end
    end
    if (s1_carry_q) grant_d = 1'b0;
  end

  // Response register; holds while the consumer stalls.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rsp_valid_q   <= 1'b0;
      rsp_granted_q <= 1'b0;
      rsp_rw_q      <= 1'b0;
      rsp_id_q      <= '0;
      rsp_addr_q    <= '0;
    end else if (rsp_advance) begin
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_granted_q <= grant_d;
        rsp_rw_q      <= s1_rw_q;
        rsp_id_q      <= s1_id_q;
        rsp_addr_q    <= s1_addr_q;
      end
    end
  end

  assign cfg_wr_en = CFG_WE && !locked_q &&
                     (32'(CFG_REGION) < NUM_MEM_REGIONS) &&
                     (32'(CFG_DOMAIN) < NUM_DOMAINS);

  // Policy table and lock; a write alongside the lock pulse still lands.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      table_q  <= POLICY_RESET;
      locked_q <= 1'b0;
    end else begin
      if (cfg_wr_en) table_q[CFG_REGION][CFG_DOMAIN] <= CFG_WDATA;
      locked_q <= locked_q | CFG_LOCK;
    end
  end

  // Violation record next state; a clear coinciding with a deny keeps that deny.
  always_comb begin
    viol_valid_d = viol_valid_q;
    viol_id_d    = viol_id_q;
    viol_addr_d  = viol_addr_q;
    viol_rw_d    = viol_rw_q;
    viol_cnt_d   = viol_cnt_q;
    if (VIOL_CLEAR) begin
      viol_valid_d = 1'b0;
      viol_id_d    = '0;
      viol_addr_d  = '0;
      viol_rw_d    = 1'b0;
      viol_cnt_d   = '0;
    end
    if (deny_hs) begin
      if (VIOL_CLEAR)              viol_cnt_d = VIOL_CNT_WIDTH'(1);
      else if (viol_cnt_q != '1)   viol_cnt_d = viol_cnt_q + 1'b1;
      if (VIOL_CLEAR || !viol_valid_q) begin
        viol_valid_d = 1'b1;
        viol_id_d    = rsp_id_q;
        viol_addr_d  = rsp_addr_q;
        viol_rw_d    = rsp_rw_q;
      end
    end
  end

  // Violation record register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      viol_valid_q <= 1'b0;
      viol_id_q    <= '0;
      viol_addr_q  <= '0;
      viol_rw_q    <= 1'b0;
      viol_cnt_q   <= '0;
    end else begin
      viol_valid_q <= viol_valid_d;
      viol_id_q    <= viol_id_d;
      viol_addr_q  <= viol_addr_d;
      viol_rw_q    <= viol_rw_d;
      viol_cnt_q   <= viol_cnt_d;
    end
  end

  assign RSP_VALID   = rsp_valid_q;
  assign RSP_GRANTED = rsp_granted_q;
  assign CFG_LOCKED  = locked_q;
  assign VIOL_VALID  = viol_valid_q;
  assign VIOL_ID     = viol_id_q;
  assign VIOL_ADDR   = viol_addr_q;
  assign VIOL_RW     = viol_rw_q;
  assign VIOL_COUNT  = viol_cnt_q;

endmodule

// File: tb/tb_policy_check_pipe.sv
// Directed bench for policy_check_pipe: vector table plus multi-cycle sequences.
module tb_policy_check_pipe;
  import axi_pkg::*;
  import pu_pkg::*;

  localparam logic [15:0][31:0] TB_REGIONS = {{14{32'h0}}, 32'h0, 32'h4000_0000};
  localparam logic [15:0][31:0] TB_LSBS    = {{14{32'd0}}, 32'd32, 32'd12};
  localparam logic [15:0][15:0] TB_DIDS    = {{14{16'h0}}, 16'h00AA, 16'h0001};

  logic          clk = 1'b0;
  logic          ARESETN, REQ_VALID, REQ_READY, REQ_RW;
  logic [15:0]   REQ_ID;
  logic [31:0]   REQ_ADDR;
  len_t          REQ_LEN;
  size_t         REQ_SIZE;
  burst_t        REQ_BURST;
  logic          RSP_VALID, RSP_READY, RSP_GRANTED;
  logic          CFG_WE, CFG_LOCK, CFG_LOCKED;
  logic [3:0]    CFG_REGION, CFG_DOMAIN;
  policy_entry_t CFG_WDATA;
  logic          VIOL_CLEAR, VIOL_VALID, VIOL_RW;
  logic [15:0]   VIOL_ID, VIOL_COUNT;
  logic [31:0]   VIOL_ADDR;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  policy_check_pipe #(
    .NUM_MEM_REGIONS (16),
    .NUM_DOMAINS     (16),
    .ID_WIDTH        (16),
    .ADDR_WIDTH      (32),
    .MEM_REGIONS     (TB_REGIONS),
    .MEM_REGION_LSBS (TB_LSBS),
    .DOMAIN_IDS      (TB_DIDS),
    .VIOL_CNT_WIDTH  (16)
  ) dut (
    .ACLK(clk), .ARESETN(ARESETN),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ID(REQ_ID), .REQ_ADDR(REQ_ADDR),
    .REQ_LEN(REQ_LEN), .REQ_SIZE(REQ_SIZE), .REQ_BURST(REQ_BURST), .REQ_RW(REQ_RW),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_GRANTED(RSP_GRANTED),
    .CFG_WE(CFG_WE), .CFG_REGION(CFG_REGION), .CFG_DOMAIN(CFG_DOMAIN), .CFG_WDATA(CFG_WDATA),
    .CFG_LOCK(CFG_LOCK), .CFG_LOCKED(CFG_LOCKED),
    .VIOL_CLEAR(VIOL_CLEAR), .VIOL_VALID(VIOL_VALID), .VIOL_ID(VIOL_ID),
    .VIOL_ADDR(VIOL_ADDR), .VIOL_RW(VIOL_RW), .VIOL_COUNT(VIOL_COUNT)
  );

  typedef struct {
    logic [15:0] id;
    logic [31:0] addr;
    len_t        len;
    size_t       size;
    burst_t      burst;
    logic        rw;
    logic        exp_grant;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    REQ_ID    = v.id;
    REQ_ADDR  = v.addr;
    REQ_LEN   = v.len;
    REQ_SIZE  = v.size;
    REQ_BURST = v.burst;
    REQ_RW    = v.rw;
  endtask

  // One request, RSP_READY high; lat counts negedges from accept to RSP_VALID.
  task automatic do_req(input vec_t v, input logic clr_on_rsp,
                        output logic granted, output int lat);
    int n;
    @(negedge clk);
    drive_req(v);
    REQ_VALID = 1'b1;
    RSP_READY = 1'b1;
    #1;
    n = 0;
    while (!REQ_READY && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    REQ_VALID = 1'b0;
    lat = 1;
    #1;
    while (!RSP_VALID && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    if (!RSP_VALID) lat = -1;
    granted = RSP_GRANTED;
    if (clr_on_rsp) VIOL_CLEAR = 1'b1;
    @(negedge clk);
    VIOL_CLEAR = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] r, input logic [3:0] d,
                           input policy_entry_t w, input logic lock);
    @(negedge clk);
    CFG_WE = 1'b1; CFG_REGION = r; CFG_DOMAIN = d; CFG_WDATA = w; CFG_LOCK = lock;
    @(negedge clk);
    CFG_WE = 1'b0; CFG_LOCK = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic   g;
    int     lat, sent, rcvd, acc, cyc;
    logic   prev_v, prev_g, prev_rdy, seen;
    vec_t   t;
    int     bp_idx [4];
    logic   bp_exp [4];

    vecs[0]  = '{16'h0001, 32'h4000_0FF0, 8'd3,  3'd2, BURST_INCR,  1'b0, 1'b1};
    vecs[1]  = '{16'h0001, 32'h4000_0FF0, 8'd3,  3'd2, BURST_INCR,  1'b1, 1'b0};
    vecs[2]  = '{16'h0001, 32'h4000_0FF8, 8'd3,  3'd2, BURST_INCR,  1'b0, 1'b0};
    vecs[3]  = '{16'h0001, 32'h4000_0FF8, 8'd3,  3'd2, BURST_WRAP,  1'b0, 1'b1};
    vecs[4]  = '{16'h00AA, 32'hFFFF_FFFC, 8'd1,  3'd2, BURST_INCR,  1'b1, 1'b0};
    vecs[5]  = '{16'h00AA, 32'hFFFF_FFF8, 8'd1,  3'd2, BURST_INCR,  1'b1, 1'b1};
    vecs[6]  = '{16'h0001, 32'h4000_0FFC, 8'd3,  3'd2, BURST_FIXED, 1'b0, 1'b1};
    vecs[7]  = '{16'h0001, 32'h4000_0FFE, 8'd3,  3'd2, BURST_FIXED, 1'b0, 1'b0};
    vecs[8]  = '{16'h0002, 32'h4000_0100, 8'd0,  3'd2, BURST_INCR,  1'b0, 1'b0};
    vecs[9]  = '{16'h00AA, 32'h4000_0100, 8'd0,  3'd2, BURST_INCR,  1'b0, 1'b1};
    vecs[10] = '{16'h0001, 32'h4000_0000, 8'd15, 3'd3, BURST_WRAP,  1'b0, 1'b1};
    vecs[11] = '{16'h0001, 32'h4000_1000, 8'd0,  3'd2, BURST_INCR,  1'b0, 1'b0};

    ARESETN = 1'b0; REQ_VALID = 1'b0; RSP_READY = 1'b1; REQ_RW = 1'b0;
    REQ_ID = '0; REQ_ADDR = '0; REQ_LEN = '0; REQ_SIZE = '0; REQ_BURST = BURST_INCR;
    CFG_WE = 1'b0; CFG_LOCK = 1'b0; CFG_REGION = '0; CFG_DOMAIN = '0; CFG_WDATA = '0;
    VIOL_CLEAR = 1'b0;
    repeat (3) @(negedge clk);
    ARESETN = 1'b1;
    @(negedge clk); #1;

    chk("rst_req_ready",  REQ_READY,   1);
    chk("rst_rsp_valid",  RSP_VALID,   0);
    chk("rst_granted",    RSP_GRANTED, 0);
    chk("rst_locked",     CFG_LOCKED,  0);
    chk("rst_viol_valid", VIOL_VALID,  0);
    chk("rst_viol_count", VIOL_COUNT,  0);

    // Empty table: first request is denied and recorded.
    t = '{16'h0001, 32'h0000_1000, 8'd0, 3'd2, BURST_INCR, 1'b0, 1'b0};
    do_req(t, 1'b0, g, lat);
    chk("first_latency",    lat,        2);
    chk("first_grant",      g,          0);
    chk("first_viol_count", VIOL_COUNT, 1);
    chk("first_viol_addr",  VIOL_ADDR,  32'h0000_1000);
    chk("first_viol_id",    VIOL_ID,    16'h0001);
    chk("first_viol_valid", VIOL_VALID, 1);
    chk("first_viol_rw",    VIOL_RW,    0);

    cfg_write(4'd0, 4'd0, policy_entry_t'{read: 1'b1, write: 1'b0}, 1'b0);
    cfg_write(4'd1, 4'd1, policy_entry_t'{read: 1'b1, write: 1'b1}, 1'b0);

    for (int i = 0; i < 12; i++) begin
      do_req(vecs[i], 1'b0, g, lat);
      chk($sformatf("vec%0d_latency", i), lat, 2);
      chk($sformatf("vec%0d_grant", i),   g,   vecs[i].exp_grant);
    end
    chk("table_viol_count", VIOL_COUNT, 7);
    chk("table_viol_addr",  VIOL_ADDR,  32'h0000_1000);

    // Back-to-back requests against a stalled consumer.
    bp_idx = '{0, 1, 3, 8};
    bp_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
    sent = 0; rcvd = 0; prev_v = 1'b0; prev_g = 1'b0; prev_rdy = 1'b1;
    for (int c = 0; c < 30 && rcvd < 4; c++) begin
      @(negedge clk);
      RSP_READY = (c >= 3);
      if (sent < 4) begin
        drive_req(vecs[bp_idx[sent]]);
        REQ_VALID = 1'b1;
      end else begin
        REQ_VALID = 1'b0;
      end
      #1;
      if (c == 2) begin
        chk("bp_ready_drop", REQ_READY, 0);
        chk("bp_accepted",   sent,      2);
      end
      if (prev_v && !prev_rdy) chk("bp_stable", {RSP_VALID, RSP_GRANTED}, {1'b1, prev_g});
      if (RSP_VALID && RSP_READY) begin
        chk($sformatf("bp_rsp%0d", rcvd), RSP_GRANTED, bp_exp[rcvd]);
        rcvd++;
      end
      prev_v = RSP_VALID; prev_g = RSP_GRANTED; prev_rdy = RSP_READY;
      if (REQ_VALID && REQ_READY) sent++;
    end
    @(negedge clk);
    REQ_VALID = 1'b0; RSP_READY = 1'b1;
    @(negedge clk);
    chk("bp_rsp_count",  rcvd,       4);
    chk("bp_viol_count", VIOL_COUNT, 9);

    // Write alongside the lock pulse lands; later writes are dropped.
    cfg_write(4'd0, 4'd0, policy_entry_t'{read: 1'b1, write: 1'b1}, 1'b1);
    chk("locked", CFG_LOCKED, 1);
    do_req(vecs[1], 1'b0, g, lat);
    chk("lock_same_cycle_write", g, 1);
    cfg_write(4'd0, 4'd0, policy_entry_t'('0), 1'b0);
    do_req(vecs[0], 1'b0, g, lat);
    chk("locked_read_grant", g, 1);
    do_req(vecs[1], 1'b0, g, lat);
    chk("locked_write_grant", g, 1);

    // Counter saturation.
    @(negedge clk); VIOL_CLEAR = 1'b1;
    @(negedge clk); VIOL_CLEAR = 1'b0;
    chk("clear_count", VIOL_COUNT, 0);
    chk("clear_valid", VIOL_VALID, 0);
    t = '{16'h0001, 32'h0000_1000, 8'd0, 3'd2, BURST_INCR, 1'b0, 1'b0};
    drive_req(t);
    RSP_READY = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 65535 && cyc < 70000) begin
      @(negedge clk);
      REQ_VALID = 1'b1;
      #1;
      if (REQ_READY) acc++;
      cyc++;
    end
    @(negedge clk);
    REQ_VALID = 1'b0;
    repeat (4) @(negedge clk);
    chk("sat_count", VIOL_COUNT, 16'hFFFF);
    chk("sat_addr",  VIOL_ADDR,  32'h0000_1000);
    t.addr = 32'h0000_3000;
    do_req(t, 1'b0, g, lat);
    chk("sat_extra_grant", g,          0);
    chk("sat_hold_count",  VIOL_COUNT, 16'hFFFF);
    chk("sat_first_kept",  VIOL_ADDR,  32'h0000_1000);

    // Clear coinciding with a deny handoff.
    t = '{16'h0002, 32'h0000_2000, 8'd0, 3'd2, BURST_INCR, 1'b0, 1'b0};
    do_req(t, 1'b1, g, lat);
    chk("clr_deny_count", VIOL_COUNT, 1);
    chk("clr_deny_valid", VIOL_VALID, 1);
    chk("clr_deny_addr",  VIOL_ADDR,  32'h0000_2000);
    chk("clr_deny_id",    VIOL_ID,    16'h0002);

    // Reset with a request in flight produces no response.
    @(negedge clk);
    drive_req(vecs[0]);
    REQ_VALID = 1'b1;
    @(negedge clk);
    REQ_VALID = 1'b0;
    #1 ARESETN = 1'b0;
    @(negedge clk);
    ARESETN = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      seen = seen | RSP_VALID;
    end
    chk("midrst_no_rsp",   seen,       0);
    chk("midrst_unlocked", CFG_LOCKED, 0);
    chk("midrst_count",    VIOL_COUNT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/policy_check_pipe.md
Name: policy_check_pipe

Overview:
- Pipelined, runtime-programmable successor to the combinational policy checker inside the ProtectionUnit.
- Accepts one AXI address-phase request per cycle over valid/ready and returns grant/deny two cycles later.
- Supports FIXED/INCR/WRAP burst span computation, a register-programmable and lockable policy table, and sticky first-violation capture with a saturating counter.
- Sits between the AR/AW channel sniffers and the gating logic of the protection unit.

Parameters:
- NUM_MEM_REGIONS, 16, number of address regions.
- NUM_DOMAINS, 16, number of ID domains.
- ID_WIDTH, 16, AXI ID width.
- ADDR_WIDTH, 32, AXI address width.
- MEM_REGIONS, all 0, per-region base address (ADDR_WIDTH each).
- MEM_REGION_LSBS, all 0, per-region LSB of the significant bits; a value >= ADDR_WIDTH matches all addresses.
- DOMAIN_IDS, all 0, per-domain ID value.
- DOMAIN_MASKS, all 16'hFFFF, per-domain ID compare mask (1 = bit compared).
- POLICY_RESET, all '0, policy table reset value (pu_pkg::policy_entry_t per region/domain).
- VIOL_CNT_WIDTH, 16, violation counter width.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  request accepted when VALID&&READY
- REQ_ID  in  ID_WIDTH  transaction ID
- REQ_ADDR  in  ADDR_WIDTH  start address
- REQ_LEN  in  axi_pkg::len_t  burst length-1
- REQ_SIZE  in  axi_pkg::size_t  beat size log2
- REQ_BURST  in  axi_pkg::burst_t  FIXED/INCR/WRAP
- REQ_RW  in  1  0 read, 1 write
- RSP_VALID  out  1  decision valid
- RSP_READY  in  1  decision consumed
- RSP_GRANTED  out  1  1 grant, 0 deny
- CFG_WE  in  1  policy table write strobe
- CFG_REGION  in  $clog2(NUM_MEM_REGIONS)  write region index
- CFG_DOMAIN  in  $clog2(NUM_DOMAINS)  write domain index
- CFG_WDATA  in  pu_pkg::policy_entry_t  read/write permission bits
- CFG_LOCK  in  1  pulse; locks the table until reset
- CFG_LOCKED  out  1  lock status
- VIOL_CLEAR  in  1  clears the violation record and counter
- VIOL_VALID  out  1  sticky: a violation was captured
- VIOL_ID  out  ID_WIDTH  ID of the first captured violation
- VIOL_ADDR  out  ADDR_WIDTH  address of the first captured violation
- VIOL_RW  out  1  direction of the first captured violation
- VIOL_COUNT  out  VIOL_CNT_WIDTH  saturating denied-request count

Behaviour:
- Reset: all valids 0, REQ_READY 1, RSP_GRANTED 0, CFG_LOCKED 0, VIOL_* 0, table = POLICY_RESET.
- Stage 1 (on accept):
  - Span: FIXED = (1<<SIZE)-1; INCR = ((LEN+1)<<SIZE)-1.
  - WRAP: checked range is the wrap container, i.e. start = ADDR aligned down to (LEN+1)<<SIZE, last = start + span.
  - Arithmetic uses ADDR_WIDTH+1 bits; a carry out of the last address forces deny.
  - Registers the region-match vector (start and last both match the significant bits), the domain-match vector, RW and carry.
- Stage 2: GRANTED = no carry AND any (region i, domain j) matched with permission for RW, using the table as of this cycle.
- Latency: accept at cycle N gives RSP_VALID at N+2 when there is no backpressure.
- Handshake:
  - Standard elastic pipeline; throughput 1 per cycle.
  - REQ_READY = !s1_valid || s2 able to advance.
  - RSP outputs hold stable while RSP_VALID && !RSP_READY.
  - No combinational path from REQ_VALID to RSP_VALID.
- Config writes:
  - A write takes effect the cycle after CFG_WE and is seen by any stage-2 evaluation in later cycles.
  - Writes are ignored while CFG_LOCKED; a write in the same cycle as CFG_LOCK is applied.
  - Out-of-range indices are ignored.
- Violations are counted when a deny is handed off (RSP_VALID && RSP_READY && !RSP_GRANTED).
  - VIOL_COUNT increments and saturates at all-ones.
  - The first deny after reset or clear loads VIOL_ID/ADDR/RW and sets VIOL_VALID; later denies do not overwrite the record.
  - VIOL_CLEAR together with a deny in the same cycle: the deny is recorded and VIOL_COUNT = 1.
- Reset mid-operation drops in-flight requests; no response is issued for them.

Decomposition:
- pu_pkg: policy_entry_t (read, write bits), region_idx_t, domain_idx_t, and a span function (addr, len, size, burst -> start, last, carry).
- One sub-module, policy_match, holds the combinational region/domain match vectors for stage 1.

Test Plan:
- Reset, then read ID 0x0001 to 0x0000_1000 with LEN 0 -> RSP_GRANTED 0 at cycle 2, VIOL_COUNT 1, VIOL_ADDR 0x1000.
- Region0 base 0x4000_0000 LSB 12, domain0 ID 0x0001; write {r=1,w=0}; INCR LEN 3 SIZE 2 read at 0x4000_0FF0 -> grant; same request as a write -> deny.
- INCR LEN 3 SIZE 2 at 0x4000_0FF8 (crosses the 4 KiB region) -> deny. WRAP with the same values -> grant (container 0x4000_0FF0..0FFF).
- ADDR 0xFFFF_FFFC, LEN 1, SIZE 2, with LSB >= 32 region permitting all -> deny on carry.
- 4 back-to-back requests with RSP_READY low for 3 cycles -> REQ_READY drops after 2 accepted; all 4 responses are issued in order with stable data.
- CFG_LOCK, then CFG_WE region0/domain0 = '0 -> the table is unchanged and grants continue. VIOL_COUNT preloaded to 0xFFFF by 65535 denies, plus one more -> stays 0xFFFF; VIOL_CLEAR with a deny in the same cycle -> count 1, VIOL_VALID 1.
